// File: rtl/w5300_pkg.sv
// Shared W5300 bus definitions: caddr fields, bus FSM states, cycle helpers.
// Used by w5300_parallel_bus and w5300_udp_conf_comm.
package w5300_pkg;

  localparam int CADDR_INVALID = 11;
  localparam int CADDR_READ    = 10;
  localparam int ADDR_W        = 10;

  localparam logic [11:0] CADDR_NONE = 12'h800;

  typedef enum logic [2:0] {
    S_RST_ASSERT,
    S_RST_WAIT,
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_GAP
  } bus_state_t;

  function automatic int unsigned us_to_cycles(
    input int unsigned us,
    input int unsigned mhz
  );
    return us * mhz;
  endfunction

endpackage

// File: rtl/w5300_delay_cnt.sv
// Loadable down-counter; done is high on the last cycle of a loaded delay.
// A load value of 0 behaves like 1.
module w5300_delay_cnt #(
  parameter int W = 20,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] val,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= (RST_VAL == '0) ? '0 : RST_VAL - 1'b1;
    end else if (load) begin
      cnt <= (val == '0) ? '0 : val - 1'b1;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/w5300_parallel_bus.sv
// W5300 direct-address parallel bus engine with power-up reset sequencing.
// Optional W5300_HW_RESET_EN: drive RESET# and wait for PLL lock after rst.
module w5300_parallel_bus
  import w5300_pkg::*;
#(
  parameter int CLK_FREQ    = 100,
  parameter int RESET_US    = 5,
  parameter int PLL_LOCK_US = 10000,
  parameter int T_SETUP     = 1,
  parameter int T_STROBE    = 7,
  parameter int T_HOLD      = 1,
  parameter int T_GAP       = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] caddr,
  input  logic [15:0] wr_data,
  output logic [15:0] rd_data,
  output logic        op_status,
  output logic        w5300_rst_n,
  output logic        w5300_cs_n,
  output logic        w5300_rd_n,
  output logic        w5300_wr_n,
  output logic [9:0]  w5300_addr,
  inout  wire  [15:0] w5300_data
);

  localparam int unsigned PLL_CYC =
    us_to_cycles(PLL_LOCK_US, CLK_FREQ);
  localparam int CW = $clog2(PLL_CYC + 1);

`ifdef W5300_HW_RESET_EN
  localparam int unsigned RST_CYC =
    us_to_cycles(RESET_US, CLK_FREQ);
  localparam bus_state_t BOOT = S_RST_ASSERT;
  localparam logic [CW-1:0] BOOT_CNT = CW'(RST_CYC);
`else
  // Chip reset handled externally: one boot cycle, then ready.
  localparam bus_state_t BOOT = S_RST_WAIT;
  localparam logic [CW-1:0] BOOT_CNT = '0;
`endif

  bus_state_t    state, nxt;
  logic          load;
  logic [CW-1:0] load_val;
  logic          done;
  logic          op_pulse;
  logic          launch;
  logic          rd_q;
  logic [15:0]   wdata;
  logic          busy;

  w5300_delay_cnt #(
    .W       (CW),
    .RST_VAL (BOOT_CNT)
  ) u_dly (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .val  (load_val),
    .done (done)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= BOOT;
    else     state <= nxt;
  end

  always_comb begin
    nxt      = state;
    load     = 1'b0;
    load_val = '0;
    op_pulse = 1'b0;
    launch   = 1'b0;
    unique case (state)
      S_RST_ASSERT: if (done) begin
        nxt      = S_RST_WAIT;
        load     = 1'b1;
        load_val = CW'(PLL_CYC);
      end
      S_RST_WAIT: if (done) begin
        nxt      = S_IDLE;
        op_pulse = 1'b1;
      end
      S_IDLE: if (!caddr[CADDR_INVALID]) begin
        nxt      = S_SETUP;
        launch   = 1'b1;
        load     = 1'b1;
        load_val = CW'(T_SETUP);
      end
      S_SETUP: if (done) begin
        nxt      = S_STROBE;
        load     = 1'b1;
        load_val = CW'(T_STROBE);
      end
      S_STROBE: if (done) begin
        nxt      = S_HOLD;
        load     = 1'b1;
        load_val = CW'(T_HOLD);
      end
      S_HOLD: if (done) begin
        nxt      = S_GAP;
        load     = 1'b1;
        load_val = CW'(T_GAP);
        op_pulse = 1'b1;
      end
      S_GAP: if (done) nxt = S_IDLE;
      default: nxt = BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_status  <= 1'b0;
      rd_data    <= '0;
      w5300_addr <= '0;
      rd_q       <= 1'b0;
      wdata      <= '0;
    end else begin
      op_status <= op_pulse;
      if (launch) begin
        w5300_addr <= caddr[ADDR_W-1:0];
        rd_q       <= caddr[CADDR_READ];
        wdata      <= wr_data;
      end
      // Sample on the last strobe cycle, while RD# is still low.
      if (state == S_STROBE && done && rd_q)
        rd_data <= w5300_data;
    end
  end

  assign busy = (state == S_SETUP) ||
                (state == S_STROBE) ||
                (state == S_HOLD);

  assign w5300_cs_n = !busy;
  assign w5300_rd_n = !(state == S_STROBE && rd_q);
  assign w5300_wr_n = !(state == S_STROBE && !rd_q);
  assign w5300_data = (busy && !rd_q) ? wdata : 16'hzzzz;

`ifdef W5300_HW_RESET_EN
  assign w5300_rst_n = (state != S_RST_ASSERT);
`else
  assign w5300_rst_n = 1'b1;
`endif

endmodule

// File: tb/tb_w5300_parallel_bus.sv
// Self-checking bench for w5300_parallel_bus with a W5300 register-file model.
// Handles both W5300_HW_RESET_EN builds.
module tb_w5300_parallel_bus;

  localparam int CLK_FREQ    = 100;
  localparam int RESET_US    = 5;
  localparam int PLL_LOCK_US = 10;
  localparam int T_SETUP     = 1;
  localparam int T_STROBE    = 7;
  localparam int T_HOLD      = 1;
  localparam int T_GAP       = 3;
  localparam int BUSY = T_SETUP + T_STROBE + T_HOLD;
  localparam int LAT  = BUSY + 1;
`ifdef W5300_HW_RESET_EN
  localparam int RST_LOW  = RESET_US * CLK_FREQ;
  localparam int PLL_WAIT = PLL_LOCK_US * CLK_FREQ;
`else
  localparam int PLL_WAIT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] caddr;
  logic [15:0] wr_data;
  logic [15:0] rd_data;
  logic        op_status;
  logic        w5300_rst_n;
  logic        w5300_cs_n;
  logic        w5300_rd_n;
  logic        w5300_wr_n;
  logic [9:0]  w5300_addr;
  wire  [15:0] bus;

  int checks = 0;
  int failures = 0;

  w5300_parallel_bus #(
    .CLK_FREQ    (CLK_FREQ),
    .RESET_US    (RESET_US),
    .PLL_LOCK_US (PLL_LOCK_US),
    .T_SETUP     (T_SETUP),
    .T_STROBE    (T_STROBE),
    .T_HOLD      (T_HOLD),
    .T_GAP       (T_GAP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .caddr       (caddr),
    .wr_data     (wr_data),
    .rd_data     (rd_data),
    .op_status   (op_status),
    .w5300_rst_n (w5300_rst_n),
    .w5300_cs_n  (w5300_cs_n),
    .w5300_rd_n  (w5300_rd_n),
    .w5300_wr_n  (w5300_wr_n),
    .w5300_addr  (w5300_addr),
    .w5300_data  (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] init_val(input logic [9:0] a);
    if (a == 10'h0FE) return 16'h5300;
    return {a[5:0], a} ^ 16'hA5C3;
  endfunction

  // Chip model: registers start at init_val, writes land on WR# low.
  logic [15:0] wmem [1024];
  bit          wvalid [1024];
  assign bus = (!w5300_rd_n && !w5300_cs_n)
             ? (wvalid[w5300_addr] ? wmem[w5300_addr]
                                   : init_val(w5300_addr))
             : 16'hzzzz;

  logic [9:0]  exp_addr = '0;
  logic [15:0] exp_w = '0;
  bit          exp_wr = 1'b0;

  int  cs_low = 0, rd_low = 0, wr_low = 0, drv = 0;
  int  addr_bad = 0, viol = 0, ops = 0, cs_falls = 0;
  int  gap = 0, min_gap = 1000;
  bit  prev_cs = 1'b1, seen_fall = 1'b0;

  always @(negedge clk) begin
    if (!w5300_cs_n) begin
      cs_low++;
      if (w5300_addr !== exp_addr) addr_bad++;
      if (exp_wr ? (bus === exp_w)
                 : (w5300_rd_n && bus !== 16'hzzzz)) drv++;
      if (prev_cs) begin
        cs_falls++;
        if (seen_fall && gap < min_gap) min_gap = gap;
        seen_fall = 1'b1;
      end
      gap = 0;
    end else begin
      gap++;
    end
    prev_cs = w5300_cs_n;
    if (!w5300_rd_n) rd_low++;
    if (!w5300_wr_n) begin
      wr_low++;
      wmem[w5300_addr] = bus;
      wvalid[w5300_addr] = 1'b1;
    end
    if ((!w5300_rd_n && !w5300_wr_n) ||
        ((!w5300_rd_n || !w5300_wr_n) && w5300_cs_n)) viol++;
    if (op_status === 1'b1) ops++;
  end

  logic [15:0] ref_mem [1024];
  logic [15:0] last_rd = '0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic power_up();
    int n, m;
    n = 0;
    m = 0;
`ifdef W5300_HW_RESET_EN
    while (w5300_rst_n === 1'b0 && n < 4 * RST_LOW + 10) begin
      n++;
      @(posedge clk); #1;
    end
    chk("rst_low_cycles", 32'(n), 32'(RST_LOW));
`else
    chk("rst_n_tied", 32'(w5300_rst_n), 32'd1);
`endif
    while (op_status !== 1'b1 && m < 4 * PLL_WAIT + 10) begin
      m++;
      @(posedge clk); #1;
    end
    chk("ready_latency", 32'(m), 32'(PLL_WAIT));
    @(posedge clk); #1;
    chk("ready_pulse_width", 32'(op_status), 32'd0);
  endtask

  task automatic do_op(input bit rd,
                       input logic [9:0] a,
                       input logic [15:0] d);
    int c0, r0, w0, d0, a0, lat;
    @(negedge clk);
    exp_addr = a;
    exp_w = d;
    exp_wr = !rd;
    c0 = cs_low; r0 = rd_low; w0 = wr_low;
    d0 = drv; a0 = addr_bad;
    caddr = {1'b0, rd, a};
    wr_data = d;
    @(posedge clk); #1;
    caddr = 12'h800 | 12'($urandom_range(0, 2047));
    wr_data = 16'($urandom);
    lat = 1;
    while (op_status !== 1'b1 && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("op_latency", 32'(lat), 32'(LAT));
    if (rd) begin
      last_rd = ref_mem[a];
      chk("rd_data", 32'(rd_data), 32'(last_rd));
    end else begin
      ref_mem[a] = d;
      chk("rd_data_kept", 32'(rd_data), 32'(last_rd));
    end
    chk("cs_low_cycles", 32'(cs_low - c0), 32'(BUSY));
    chk("rd_low_cycles", 32'(rd_low - r0), rd ? 32'(T_STROBE) : 32'd0);
    chk("wr_low_cycles", 32'(wr_low - w0), rd ? 32'd0 : 32'(T_STROBE));
    chk("data_drive", 32'(drv - d0), rd ? 32'd0 : 32'(BUSY));
    chk("addr_stable", 32'(addr_bad - a0), 32'd0);
    repeat (T_GAP) @(posedge clk);
  endtask

  logic [9:0] pool [4];
  int o0, f0;

  initial begin
    rst = 1'b1;
    caddr = 12'h800;
    wr_data = '0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_val(10'(i));
    pool[0] = 10'h0FE;
    pool[1] = 10'h3A5;
    pool[2] = 10'h011;
    pool[3] = 10'h200;

    repeat (3) @(posedge clk); #1;
    chk("rst_op_status", 32'(op_status), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
`ifdef W5300_HW_RESET_EN
    chk("rst_rst_n", 32'(w5300_rst_n), 32'd0);
`else
    chk("rst_rst_n", 32'(w5300_rst_n), 32'd1);
`endif
    chk("rst_cs_n", 32'(w5300_cs_n), 32'd1);
    chk("rst_rd_n", 32'(w5300_rd_n), 32'd1);
    chk("rst_wr_n", 32'(w5300_wr_n), 32'd1);
    chk("rst_addr", 32'(w5300_addr), 32'd0);
    chk("rst_data_z", 32'(bus === 16'hzzzz), 32'd1);

    @(negedge clk);
    rst = 1'b0;
    power_up();

    do_op(1'b1, 10'h0FE, 16'h0000);
    do_op(1'b0, 10'h000, 16'h0002);
    do_op(1'b1, 10'h000, 16'h0000);

    for (int i = 0; i < 16; i++) begin
      do_op(1'($urandom_range(0, 1)),
            pool[$urandom_range(0, 3)],
            16'($urandom));
    end

    @(negedge clk);
    o0 = ops;
    f0 = cs_falls;
    exp_addr = 10'h202;
    exp_w = 16'h1234;
    exp_wr = 1'b1;
    caddr = 12'h202;
    wr_data = 16'h1234;
    repeat (60) @(posedge clk);
    @(negedge clk);
    caddr = 12'h800;
    repeat (20) @(posedge clk); #1;
    ref_mem[10'h202] = 16'h1234;
    chk("b2b_op_pulses", 32'(ops - o0), 32'd5);
    chk("b2b_cs_falls", 32'(cs_falls - f0), 32'd5);
    chk("b2b_min_gap", 32'(min_gap >= T_GAP), 32'd1);

    @(negedge clk);
    o0 = ops;
    f0 = cs_falls;
    caddr = 12'hFFF;
    repeat (40) @(posedge clk); #1;
    chk("idle_cs_falls", 32'(cs_falls - f0), 32'd0);
    chk("idle_op_pulses", 32'(ops - o0), 32'd0);
    chk("idle_cs_n", 32'(w5300_cs_n), 32'd1);
    caddr = 12'h800;

    do_op(1'b1, 10'h202, 16'h0000);

    @(negedge clk);
    exp_addr = 10'h0FE;
    exp_wr = 1'b0;
    caddr = 12'h4FE;
    @(posedge clk); #1;
    caddr = 12'h800;
    @(posedge clk); #1;
    chk("abort_rd_low", 32'(w5300_rd_n), 32'd0);
    o0 = ops;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_rd_n", 32'(w5300_rd_n), 32'd1);
    chk("abort_wr_n", 32'(w5300_wr_n), 32'd1);
    chk("abort_cs_n", 32'(w5300_cs_n), 32'd1);
    chk("abort_data_z", 32'(bus === 16'hzzzz), 32'd1);
`ifdef W5300_HW_RESET_EN
    chk("abort_rst_n", 32'(w5300_rst_n), 32'd0);
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    power_up();
    chk("abort_no_pulse", 32'(ops - o0), 32'd1);
    chk("abort_rd_data", 32'(rd_data), 32'd0);
    last_rd = '0;

    do_op(1'b1, 10'h3A5, 16'h0000);

    chk("strobe_rules", 32'(viol), 32'd0);
    chk("gap_min_all", 32'(min_gap >= T_GAP), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
